lcd_cmd_seq: RTL and testbench
==============================

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 SHALL have parameter CMD_AW, default 6, meaning command-ROM address width (64 entries).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning prefetch FIFO entries (power of 2).
REQ-003 SHALL have parameter WDOG_CYCLES, default 1024, meaning cycles allowed from last issue to done.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to run a command list.
REQ-007 SHALL have port cmd_num, input, CMD_AW, count of commands to issue; sampled on accepted start.
REQ-008 SHALL have port CMD_EN, output, 1, command-ROM chip enable, active low.
REQ-009 SHALL have port CMD_A, output, CMD_AW, command-ROM address.
REQ-010 SHALL have port CMD_Q, input, 3, command-ROM data, valid one cycle after CMD_EN low.
REQ-011 SHALL have ports cmd (output, 3) and cmd_valid (output, 1), command to the LCD controller.
REQ-012 SHALL have ports busy (input, 1) and done (input, 1), LCD controller status.
REQ-013 SHALL have ports seq_busy (output, 1), seq_done (output, 1, one-cycle pulse), issued_cnt (output, CMD_AW), wdog_err (output, 1).

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, FIN; FIN returns to IDLE after one cycle.
REQ-015 SHALL leave IDLE for RUN on start=1 with cmd_num!=0; start with cmd_num=0, or start outside IDLE, SHALL be ignored.
REQ-016 SHALL in RUN fetch addresses 0..cmd_num-1 in order, driving CMD_EN=0 for one fetch only while FIFO occupancy plus reads in flight < FIFO_DEPTH.
REQ-017 SHALL push CMD_Q into the FIFO exactly one cycle after each fetch; a full FIFO SHALL never be overrun.
REQ-018 SHALL drive cmd from the FIFO head with cmd_valid=1 whenever the FIFO is non-empty in RUN.
REQ-019 SHALL count a command as transferred on a rising edge with cmd_valid=1 and busy=0; it then pops the FIFO and increments issued_cnt.
REQ-020 SHALL hold cmd and cmd_valid stable while busy=1.
REQ-021 SHALL allow a same-cycle push and pop without changing occupancy.
REQ-022 SHALL move RUN to DRAIN on the edge that transfers command cmd_num; cmd_valid=0 from the next cycle.
REQ-023 SHALL ignore done in IDLE and RUN; done=1 in DRAIN SHALL move the FSM to FIN.
REQ-024 SHALL pulse seq_done=1 for exactly the FIN cycle.
REQ-025 SHALL drive seq_busy=1 in RUN and DRAIN, 0 otherwise.
REQ-026 SHALL keep issued_cnt until the next accepted start, which clears it to 0.

Reset
REQ-027 SHALL on reset=1 at a clock edge enter IDLE, flush the FIFO and cancel in-flight reads.
REQ-028 SHALL reset outputs to: CMD_EN=1, CMD_A=0, cmd=0, cmd_valid=0, seq_busy=0, seq_done=0, issued_cnt=0, wdog_err=0.
REQ-029 SHALL, when reset occurs mid-run, discard any CMD_Q data returning on the following cycle.

Configuration
REQ-030 SHALL, with LCD_SEQ_WDOG_EN defined, count DRAIN cycles and go to FIN with wdog_err=1 if done has not arrived after WDOG_CYCLES cycles.
REQ-031 SHALL keep wdog_err=1 until the next accepted start or reset.
REQ-032 SHALL, without LCD_SEQ_WDOG_EN, omit the counter, tie wdog_err to 0 and wait in DRAIN indefinitely.

Structure
REQ-033 SHALL take the state encoding (IDLE=0, RUN=1, DRAIN=2, FIN=3) and the 3-bit command codes (0 write .. 7 mirror Y) from shared package lcd_pkg.
REQ-034 SHALL place the prefetch FIFO in sub-module lcd_cmd_fifo, with push, pop, full, empty and flush ports.

Verification
REQ-035 SHALL verify: ROM = {0,1,2,3,4,5,6,7}, cmd_num=8, busy held low -> 8 transfers with cmd 0..7 on consecutive cycles; done then gives seq_done pulse and issued_cnt=8.
REQ-036 SHALL verify: busy=1 for 3 cycles after each transfer, cmd_num=5 -> cmd stable while busy; exactly 5 transfers; FIFO occupancy never exceeds 4.
REQ-037 SHALL verify: start with cmd_num=0, and start during RUN -> no state change, no fetch, issued_cnt unchanged.
REQ-038 SHALL verify: reset asserted after 2 of 6 transfers -> next cycle all outputs at reset values; a fresh start with cmd_num=6 issues ROM entries 0..5.
REQ-039 SHALL verify: done pulsed during RUN, before the last transfer -> ignored; seq_done only after done in DRAIN.
REQ-040 SHALL verify: with LCD_SEQ_WDOG_EN and WDOG_CYCLES=16, done withheld -> wdog_err=1 and seq_done pulse 16 cycles after entering DRAIN.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types for the LCD command sequencer.
// Holds the sequencer state encoding and the 3-bit LCD command codes.
package lcd_pkg;

    localparam int CMD_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } seq_state_t;

    typedef enum logic [CMD_W-1:0] {
        C_WRITE    = 3'd0,
        C_READ     = 3'd1,
        C_CLEAR    = 3'd2,
        C_HOME     = 3'd3,
        C_DISP_ON  = 3'd4,
        C_DISP_OFF = 3'd5,
        C_MIRROR_X = 3'd6,
        C_MIRROR_Y = 3'd7
    } lcd_cmd_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Prefetch FIFO holding command-ROM words until the LCD takes them.
// Ports: clk, flush (sync clear), push/din, pop/dout, full, empty, count.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [CMD_W-1:0]         din,
    output logic [CMD_W-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_V);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Reads a list of commands from a command ROM and hands them to an LCD
// controller with a valid/busy handshake, then waits for the LCD done.
// Ports: clk, reset (sync, active high), start/cmd_num request;
// CMD_EN (active low)/CMD_A/CMD_Q command ROM; cmd/cmd_valid/busy/done
// LCD side; seq_busy, seq_done pulse, issued_cnt, wdog_err status.
// Build option: define LCD_SEQ_WDOG_EN to enable the DRAIN watchdog.
module lcd_cmd_seq
    import lcd_pkg::*;
#(
    parameter int CMD_AW      = 6,
    parameter int FIFO_DEPTH  = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CMD_AW-1:0] cmd_num,
    output logic              CMD_EN,
    output logic [CMD_AW-1:0] CMD_A,
    input  logic [CMD_W-1:0]  CMD_Q,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_valid,
    input  logic              busy,
    input  logic              done,
    output logic              seq_busy,
    output logic              seq_done,
    output logic [CMD_AW-1:0] issued_cnt,
    output logic              wdog_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    seq_state_t        state;
    logic [CMD_AW-1:0] num;
    logic [CMD_AW-1:0] fetch_cnt;
    logic              rd_pend;
    logic [CW-1:0]     occ;
    logic              full;
    logic              empty;
    logic [CMD_W-1:0]  head;
    logic              xfer;
    logic              can_fetch;
    logic [CW:0]       pipe_sum;

    // Every word that is stored, being read, or about to return
    // already owns a FIFO slot, so the FIFO can never overflow.
    assign pipe_sum  = {1'b0, occ}
                     + {{CW{1'b0}}, !CMD_EN}
                     + {{CW{1'b0}}, rd_pend};
    assign can_fetch = (state == ST_RUN) && (fetch_cnt != num)
                     && !full && (pipe_sum < DEPTH_V);

    assign cmd_valid = (state == ST_RUN) && !empty;
    assign cmd       = cmd_valid ? head : '0;
    assign xfer      = cmd_valid && !busy;

    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .flush (reset),
        .push  (rd_pend),
        .pop   (xfer),
        .din   (CMD_Q),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

`ifdef LCD_SEQ_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);
    logic [WW-1:0] wd_cnt;
`else
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            CMD_EN     <= 1'b1;
            CMD_A      <= '0;
            num        <= '0;
            fetch_cnt  <= '0;
            rd_pend    <= 1'b0;
            seq_busy   <= 1'b0;
            seq_done   <= 1'b0;
            issued_cnt <= '0;
`ifdef LCD_SEQ_WDOG_EN
            wd_cnt     <= '0;
            wdog_err   <= 1'b0;
`endif
        end else begin
            // ROM data is valid the cycle after CMD_EN was low
            rd_pend  <= !CMD_EN;
            CMD_EN   <= !can_fetch;
            seq_done <= 1'b0;
            if (can_fetch) begin
                CMD_A     <= fetch_cnt;
                fetch_cnt <= fetch_cnt + 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start && (cmd_num != '0)) begin
                        state      <= ST_RUN;
                        num        <= cmd_num;
                        fetch_cnt  <= '0;
                        issued_cnt <= '0;
                        seq_busy   <= 1'b1;
`ifdef LCD_SEQ_WDOG_EN
                        wdog_err   <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        issued_cnt <= issued_cnt + 1'b1;
                        if (issued_cnt + 1'b1 == num) begin
                            state <= ST_DRAIN;
                        end
`ifdef LCD_SEQ_WDOG_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (done) begin
                        state    <= ST_FIN;
                        seq_busy <= 1'b0;
                        seq_done <= 1'b1;
`ifdef LCD_SEQ_WDOG_EN
                    end else if (wd_cnt == WD_LAST) begin
                        state    <= ST_FIN;
                        seq_busy <= 1'b0;
                        seq_done <= 1'b1;
                        wdog_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Self-checking bench for lcd_cmd_seq: table of command-list runs plus
// hand-written sequences for reset mid-run, ignored starts and watchdog.
module tb_lcd_cmd_seq;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] cmd_num;
    logic          CMD_EN;
    logic [AW-1:0] CMD_A;
    logic [2:0]    CMD_Q = 3'd0;
    logic [2:0]    cmd;
    logic          cmd_valid;
    logic          busy;
    logic          done;
    logic          seq_busy;
    logic          seq_done;
    logic [AW-1:0] issued_cnt;
    logic          wdog_err;

    logic [2:0] rom [64];
    int total = 0;
    int bad = 0;

    typedef struct {
        int n;
        int gap;
        bit early;
        bit restart;
        int exp_xfers;
        int exp_span;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    lcd_cmd_seq #(
        .CMD_AW(AW), .FIFO_DEPTH(4), .WDOG_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cmd_num(cmd_num),
        .CMD_EN(CMD_EN), .CMD_A(CMD_A), .CMD_Q(CMD_Q),
        .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
        .seq_busy(seq_busy), .seq_done(seq_done),
        .issued_cnt(issued_cnt), .wdog_err(wdog_err)
    );

    // Synchronous command ROM: data one cycle after CMD_EN low
    always @(posedge clk) begin
        if (!CMD_EN) CMD_Q <= rom[CMD_A];
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_en"}, CMD_EN, 1);
        check({tag, "_cmd_a"}, CMD_A, 0);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_seq_busy"}, seq_busy, 0);
        check({tag, "_seq_done"}, seq_done, 0);
        check({tag, "_issued"}, issued_cnt, 0);
        check({tag, "_wdog"}, wdog_err, 0);
    endtask

    // Starts a list and runs it until n transfers, modelling LCD busy.
    task automatic run_phase(input int n, input int gap, input bit early,
                             input bit restart, output int xfers,
                             output int span, output int max_out);
        int fetches, busy_left, cyc, first_c, last_c;
        bit hold, tr;
        logic [2:0] held;
        xfers = 0; fetches = 0; busy_left = 0; cyc = 0;
        first_c = -1; last_c = -1; hold = 0; held = 0; max_out = 0;
        busy = 0; done = 0;
        cmd_num = AW'(n);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("accept_busy", seq_busy, 1);
        check("accept_clr", issued_cnt, 0);
        while (xfers < n && cyc < 3000) begin
            @(negedge clk);
            if (!CMD_EN) fetches++;
            if (fetches - xfers > max_out) max_out = fetches - xfers;
            if (hold) check("hold_stable", cmd, held);
            tr = cmd_valid && !busy;
            if (tr) begin
                check("cmd_order", cmd, rom[xfers]);
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                xfers++;
            end
            hold = cmd_valid && busy;
            held = cmd;
            @(posedge clk); #1;
            start = 0;
            done = 0;
            if (tr) busy_left = gap;
            else if (busy_left > 0) busy_left--;
            busy = (busy_left > 0);
            if (restart && cyc == 1) begin
                start = 1;
                cmd_num = AW'(20);
            end
            if (early && xfers == 1) done = 1;
            cyc++;
        end
        span = last_c - first_c;
        busy = 0; start = 0; done = 0;
    endtask

    // Called right after the last transfer edge: DRAIN, then done.
    task automatic finish_drain(input int n);
        check("drain_cnt", issued_cnt, n);
        check("drain_valid", cmd_valid, 0);
        check("drain_busy", seq_busy, 1);
        repeat (3) @(posedge clk);
        #1;
        check("no_early_done", seq_done, 0);
        check("wait_busy", seq_busy, 1);
        done = 1;
        @(posedge clk); #1;
        done = 0;
        check("seq_done", seq_done, 1);
        check("fin_busy", seq_busy, 0);
        check("fin_wdog", wdog_err, 0);
        @(posedge clk); #1;
        check("done_pulse", seq_done, 0);
        check("keep_cnt", issued_cnt, n);
    endtask

    initial begin
        int xf, sp, mo, k, x;
        for (int i = 0; i < 64; i++) rom[i] = 3'(i % 8);
        vecs[0] = '{8, 0, 0, 0, 8, 7};
        vecs[1] = '{5, 3, 0, 0, 5, 16};
        vecs[2] = '{6, 1, 1, 0, 6, 10};
        vecs[3] = '{4, 0, 0, 1, 4, 3};
        vecs[4] = '{1, 2, 0, 0, 1, 0};
        vecs[5] = '{63, 0, 0, 0, 63, 62};

        reset = 1; start = 0; busy = 0; done = 0; cmd_num = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        reset = 0;

        start = 1; cmd_num = '0;
        @(posedge clk); #1;
        start = 0;
        check("zero_busy", seq_busy, 0);
        @(posedge clk); #1;
        check("zero_nofetch", CMD_EN, 1);
        check("zero_cnt", issued_cnt, 0);

        for (int i = 0; i < 6; i++) begin
            run_phase(vecs[i].n, vecs[i].gap, vecs[i].early,
                      vecs[i].restart, xf, sp, mo);
            check("xfers", xf, vecs[i].exp_xfers);
            check("span", sp, vecs[i].exp_span);
            check("occupancy_le4", int'(mo <= 4), 1);
            finish_drain(vecs[i].n);
        end

        start = 1; cmd_num = '0;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        check("zero2_busy", seq_busy, 0);
        check("zero2_nofetch", CMD_EN, 1);
        check("zero2_cnt", issued_cnt, 63);

        cmd_num = AW'(6); start = 1;
        @(posedge clk); #1;
        start = 0;
        k = 0; x = 0;
        while (x < 2 && k < 50) begin
            @(negedge clk);
            if (cmd_valid) x++;
            @(posedge clk); #1;
            k++;
        end
        check("mid_xfers", x, 2);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check_reset("mid");
        @(posedge clk); #1;
        check("post_valid", cmd_valid, 0);
        check("post_en", CMD_EN, 1);
        run_phase(6, 0, 0, 0, xf, sp, mo);
        check("fresh_xfers", xf, 6);
        finish_drain(6);

`ifdef LCD_SEQ_WDOG_EN
        run_phase(2, 0, 0, 0, xf, sp, mo);
        k = 0;
        while (!seq_done && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("wdog_cycles", k, 16);
        check("wdog_err", wdog_err, 1);
        check("wdog_fin_busy", seq_busy, 0);
        @(posedge clk); #1;
        check("wdog_hold", wdog_err, 1);
        run_phase(1, 0, 0, 0, xf, sp, mo);
        check("wdog_clear", wdog_err, 0);
        finish_drain(1);
`else
        run_phase(2, 0, 0, 0, xf, sp, mo);
        k = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (seq_done) k++;
        end
        check("nowd_no_done", k, 0);
        check("nowd_busy", seq_busy, 1);
        check("nowd_err", wdog_err, 0);
        finish_drain(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
